uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- 8N1 UART transmitter, the sending counterpart of the team's UART receiver, in the Clk_100M domain.
- Takes one byte per Send/Busy handshake from user logic (echo path, LED/debug console).
- Serialises the byte LSB-first onto Tx at the same baud as the receiver, so both share the divisor parameters.

Parameters:
N, 14, width of the baud counter.
Count, 14'd9999, baud counter terminal value; bit period = Count+1 clocks (10 kbaud at 100 MHz). Must fit in N bits and be >= 1.

Ports:
Clk_100M  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset (0 = reset)
Data  input  8  byte to transmit, sampled only on the accept edge
Send  input  1  transmit request; level-sensitive
Busy  output  1  high while a frame is in progress; Send is ignored while high
Done  output  1  one-cycle pulse when the stop bit completes
Tx  output  1  serial line, idle high

Behaviour:
- Reset (Reset==0 at a rising edge): Tx=1, Busy=0, Done=0, state IDLE, baud counter 0, bit index 0, shift register 0. Reset mid-frame aborts the frame; Tx returns high on that edge; the byte is discarded.
- Accept: at an edge with Reset==1, state IDLE and Send==1, latch Data into the shift register and set Tx=0 (start bit), Busy=1, counter=0, state START. Latency from Send to the start bit on Tx is one edge.
- Send while Busy==1 is ignored. Data is not resampled after accept.
- States:
  - IDLE: Tx=1.
  - START: Tx=0.
  - DATA: Tx = shift[0].
  - STOP: Tx=1.
- Baud counter:
  - Increments every clock outside IDLE.
  - When it equals Count, it wraps to 0 and the bit ends.
  - Each bit therefore lasts exactly Count+1 clocks.
- Transitions at bit end:
  - START -> DATA: bit index 0, Tx=shift[0].
  - DATA -> DATA: shift right, index+1, while index<7.
  - DATA -> STOP: after index 7.
  - STOP -> IDLE: Busy=0, Done=1 for exactly one cycle.
- Frame timing:
  - Busy is high for exactly 10*(Count+1) cycles.
  - Tx order: 0, d0..d7, 1.
- Back-to-back frames: if Send is held high, the next accept happens on the edge after Busy falls, i.e. at least one idle-high clock between the stop bit and the next start bit. Done and the new accept never coincide.
- Counter and bit index arithmetic: unsigned, no overflow paths; the index is 3 bits.
- No parity, no break generation, no flow control.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1, default N=14 and Count=14'd9999.
  - State encoding localparams IDLE/START/DATA/STOP.
  - The receiver uses the same package, so baud and framing cannot drift between the two.
- One sub-module: uart_baud_tick (N, Count), a counter with enable and clear that emits a one-cycle tick at Count. The FSM and shifter stay in uart_transmitter.

Test Plan:
1. Reset: hold Reset=0 for 5 cycles with Send=1 -> Tx=1, Busy=0, Done=0 throughout; no frame starts.
2. Single byte, Count=3, Data=8'hA5, Send pulsed 1 cycle:
   - Tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   - Busy high for 40 cycles; Done high for 1 cycle at the end.
3. Ignore while busy: send 8'h41, then pulse Send with Data=8'hFF mid-frame -> frame carries 8'h41 only; no second frame.
4. Back-to-back, Count=3: hold Send=1 with 8'h00 then 8'hFF -> two frames; exactly 1 idle-high cycle between the stop bit and the second start bit.
5. Reset mid-frame: assert Reset=0 during data bit 3 -> Tx=1, Busy=0 on that edge; a subsequent Send of 8'h55 yields a clean full frame.
6. Default Count=9999 loopback into the UART receiver with 8'h72 ("r") -> receiver outputs 8'h72; each bit measured as 10000 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing and baud constants. The receiver imports the same package,
// so both ends agree on frame format and bit period.
package uart_pkg;

  localparam int          UART_DATA_BITS = 8;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;
  localparam int          BAUD_N         = 14;
  localparam logic [13:0] BAUD_COUNT     = 14'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic logic is_last_bit(input logic [2:0] idx);
    return idx == 3'(UART_DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud period counter: counts 0..Count while enabled and flags the final clock
// of each bit period so the FSM can advance.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int           N     = BAUD_N,
  parameter logic [N-1:0] Count = N'(BAUD_COUNT)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == Count);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == Count) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + N'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: takes one byte per Send/Busy handshake and shifts it out
// LSB-first on Tx as start bit, eight data bits, stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int           N     = BAUD_N,
  parameter logic [N-1:0] Count = N'(BAUD_COUNT)
) (
  input  logic                      Clk_100M,
  input  logic                      Reset,
  input  logic [UART_DATA_BITS-1:0] Data,
  input  logic                      Send,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Tx
);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      bit_end;
  logic                      baud_en;
  logic                      baud_clr;

  // The counter idles at zero so every accepted frame starts a full bit period.
  assign baud_en  = (state_q != IDLE);
  assign baud_clr = (state_q == IDLE);

  uart_baud_tick #(
    .N     (N),
    .Count (Count)
  ) u_baud (
    .clk_i  (Clk_100M),
    .rst_ni (Reset),
    .en_i   (baud_en),
    .clr_i  (baud_clr),
    .tick_o (bit_end)
  );

  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Send) state_d = START; else state_d = IDLE;
      START:   if (bit_end) state_d = DATA; else state_d = START;
      DATA:    if (bit_end && is_last_bit(idx_q)) state_d = STOP; else state_d = DATA;
      STOP:    if (bit_end) state_d = IDLE; else state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so Tx changes on the same edge as the FSM.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Send) begin
          shift_d = Data;
          idx_d   = 3'd0;
        end else begin
          shift_d = shift_q;
        end
      end
      START: begin
        if (bit_end) idx_d = 3'd0; else idx_d = idx_q;
      end
      DATA: begin
        if (bit_end && !is_last_bit(idx_q)) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      STOP: begin
        done_d = bit_end;
      end
      default: begin
        shift_d = '0;
        idx_d   = 3'd0;
      end
    endcase

    tx_d = STOP_BIT;
    case (state_d)
      IDLE:    tx_d = STOP_BIT;
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = STOP_BIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      shift_q <= '0;
      idx_q   <= 3'd0;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
